// File: rtl/mean_square_acc_if.sv
// Sample-in / radicand-out bundle between the RMS front end and its neighbours.
interface mean_square_acc_if #(
  parameter int unsigned SAMPLE_BITS = 32,
  parameter int unsigned OUTPUT_BITS = 64
);
  logic                   sample_valid;
  logic [SAMPLE_BITS-1:0] sample;
  logic                   clear;
  logic [OUTPUT_BITS-1:0] radicand;
  logic                   start;
  logic                   overflow;

  modport master (
    output sample_valid, sample, clear,
    input  radicand, start, overflow
  );

  modport slave (
    input  sample_valid, sample, clear,
    output radicand, start, overflow
  );
endinterface

// File: rtl/mean_square_acc.sv
// Squares signed samples and averages windows of 2^LOG2_WINDOW squares for the sqrt stage.
// Define MS_SLIDING_WINDOW_EN for a sliding window that emits a mean on every sample.
module mean_square_acc #(
  parameter int unsigned SAMPLE_BITS = 32,
  parameter int unsigned LOG2_WINDOW = 4,
  parameter int unsigned OUTPUT_BITS = 64
) (
  input logic             clk,
  input logic             rst,
  mean_square_acc_if.slave bus
);
  localparam int unsigned N    = 2 ** LOG2_WINDOW;
  localparam int unsigned SqW  = 2 * SAMPLE_BITS;
  localparam int unsigned AccW = SqW + LOG2_WINDOW;
  localparam int unsigned ExtW = (OUTPUT_BITS > AccW) ? OUTPUT_BITS : AccW;

  logic [SAMPLE_BITS-1:0] abs_q, abs_d;
  logic                   abs_vld_q, abs_vld_d;
  logic [SqW-1:0]         sq_q, sq_d;
  logic                   sq_vld_q, sq_vld_d;
  logic [LOG2_WINDOW-1:0] count_q, count_d;
  logic [AccW-1:0]        acc_q, acc_d, total;
  logic [ExtW-1:0]        mean;
  logic [OUTPUT_BITS-1:0] radicand_q, radicand_d;
  logic                   start_q, start_d;
  logic                   overflow_q, overflow_d;
  logic                   last, emit, take;

  assign last = (count_q == LOG2_WINDOW'(N - 1));
  // A square arriving alongside clear belongs to the flushed window.
  assign take = sq_vld_q & ~bus.clear;

`ifdef MS_SLIDING_WINDOW_EN
  logic [SqW-1:0] sq_buf_q [N];
  logic           fill_q, fill_d;
  logic [SqW-1:0] oldest;

  assign oldest = fill_q ? sq_buf_q[count_q] : '0;
  assign total  = acc_q + AccW'(sq_q) - AccW'(oldest);
  assign emit   = fill_q | last;
`else
  assign total  = acc_q + AccW'(sq_q);
  assign emit   = last;
`endif

  assign mean = ExtW'(total >> LOG2_WINDOW);

  always_comb begin
    abs_d      = bus.sample[SAMPLE_BITS-1] ? ('0 - bus.sample) : bus.sample;
    abs_vld_d  = bus.sample_valid & ~bus.clear;
    sq_d       = SqW'(abs_q) * SqW'(abs_q);
    sq_vld_d   = abs_vld_q & ~bus.clear;
    count_d    = count_q;
    acc_d      = acc_q;
    start_d    = 1'b0;
    radicand_d = radicand_q;
    overflow_d = overflow_q;
`ifdef MS_SLIDING_WINDOW_EN
    fill_d     = fill_q;
`endif
    if (take) begin
      count_d = LOG2_WINDOW'(count_q + 1);
`ifdef MS_SLIDING_WINDOW_EN
      acc_d   = total;
      fill_d  = fill_q | last;
`else
      acc_d   = last ? '0 : total;
`endif
      if (emit) begin
        start_d = 1'b1;
        if (mean > ExtW'({OUTPUT_BITS{1'b1}})) begin
          radicand_d = '1;
          overflow_d = 1'b1;
        end else begin
          radicand_d = mean[OUTPUT_BITS-1:0];
          overflow_d = 1'b0;
        end
      end
    end
    if (bus.clear) begin
      count_d = '0;
      acc_d   = '0;
`ifdef MS_SLIDING_WINDOW_EN
      fill_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      abs_q      <= '0;
      abs_vld_q  <= 1'b0;
      sq_q       <= '0;
      sq_vld_q   <= 1'b0;
      count_q    <= '0;
      acc_q      <= '0;
      radicand_q <= '0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      abs_q      <= abs_d;
      abs_vld_q  <= abs_vld_d;
      sq_q       <= sq_d;
      sq_vld_q   <= sq_vld_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      radicand_q <= radicand_d;
      start_q    <= start_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef MS_SLIDING_WINDOW_EN
  always_ff @(posedge clk) begin
    if (!rst || bus.clear) begin
      fill_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) sq_buf_q[i] <= '0;
    end else begin
      fill_q <= fill_d;
      if (take) sq_buf_q[count_q] <= sq_q;
    end
  end
`endif

  assign bus.radicand = radicand_q;
  assign bus.start    = start_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_mean_square_acc.sv
// Directed checks of mean_square_acc across three parameter sets sharing one clock and reset.
module tb_mean_square_acc;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mean_square_acc_if #(.SAMPLE_BITS(32), .OUTPUT_BITS(64)) bus_a ();
  mean_square_acc_if #(.SAMPLE_BITS(32), .OUTPUT_BITS(64)) bus_b ();
  mean_square_acc_if #(.SAMPLE_BITS(16), .OUTPUT_BITS(16)) bus_c ();

  mean_square_acc #(.SAMPLE_BITS(32), .LOG2_WINDOW(2), .OUTPUT_BITS(64)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  mean_square_acc #(.SAMPLE_BITS(32), .LOG2_WINDOW(4), .OUTPUT_BITS(64)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );
  mean_square_acc #(.SAMPLE_BITS(16), .LOG2_WINDOW(2), .OUTPUT_BITS(16)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put_a(input logic v, input logic [31:0] s);
    bus_a.sample_valid = v;
    bus_a.sample       = s;
  endtask

  task automatic put_b(input logic v, input logic [31:0] s);
    bus_b.sample_valid = v;
    bus_b.sample       = s;
  endtask

  task automatic put_c(input logic v, input logic [15:0] s);
    bus_c.sample_valid = v;
    bus_c.sample       = s;
  endtask

  initial begin
    int samp [4];
    samp = '{3, -4, 5, -6};
    rst = 1'b0;
    bus_a.clear = 1'b0;
    bus_b.clear = 1'b0;
    bus_c.clear = 1'b0;
    put_a(1'b1, 32'd7);
    put_b(1'b0, 32'd0);
    put_c(1'b0, 16'd0);

    // Reset held with a valid sample present
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_a_radicand", 64'(bus_a.radicand), 64'd0);
      chk("rst_a_start", 64'(bus_a.start), 64'd0);
      chk("rst_a_overflow", 64'(bus_a.overflow), 64'd0);
    end
    chk("rst_b_radicand", 64'(bus_b.radicand), 64'd0);
    chk("rst_c_radicand", 64'(bus_c.radicand), 64'd0);
    chk("rst_c_overflow", 64'(bus_c.overflow), 64'd0);
    rst = 1'b1;
    put_a(1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_start", 64'(bus_a.start), 64'd0);
    end

`ifdef MS_SLIDING_WINDOW_EN
    // Sliding: 1,2,3,4 -> 30>>2=7; then 5 -> (30+25-1)>>2=13
    for (int i = 1; i <= 5; i++) begin
      put_a(1'b1, 32'(i));
      tick();
      chk("slide_no_early_start", 64'(bus_a.start), 64'd0);
    end
    put_a(1'b0, 32'd0);
    tick();
    chk("slide_start1", 64'(bus_a.start), 64'd1);
    chk("slide_radicand1", 64'(bus_a.radicand), 64'd7);
    tick();
    chk("slide_start2", 64'(bus_a.start), 64'd1);
    chk("slide_radicand2", 64'(bus_a.radicand), 64'd13);
    tick();
    chk("slide_start_drop", 64'(bus_a.start), 64'd0);
`else
    // Consecutive 3,-4,5,-6 -> 86>>2 = 21
    for (int i = 0; i < 4; i++) begin
      put_a(1'b1, 32'(samp[i]));
      tick();
      chk("blk_no_early_start", 64'(bus_a.start), 64'd0);
    end
    put_a(1'b0, 32'd0);
    tick();
    chk("blk_start_k1", 64'(bus_a.start), 64'd0);
    tick();
    chk("blk_start_k2", 64'(bus_a.start), 64'd1);
    chk("blk_radicand", 64'(bus_a.radicand), 64'd21);
    chk("blk_overflow", 64'(bus_a.overflow), 64'd0);
    tick();
    chk("blk_start_one_cycle", 64'(bus_a.start), 64'd0);
    chk("blk_radicand_hold", 64'(bus_a.radicand), 64'd21);

    // Same samples with 1..3 idle cycles between them
    for (int i = 0; i < 4; i++) begin
      put_a(1'b1, 32'(samp[i]));
      tick();
      chk("gap_no_start_accept", 64'(bus_a.start), 64'd0);
      put_a(1'b0, 32'd0);
      if (i < 3) begin
        for (int j = 0; j <= i; j++) begin
          tick();
          chk("gap_no_start_idle", 64'(bus_a.start), 64'd0);
        end
      end
    end
    tick();
    chk("gap_start_k1", 64'(bus_a.start), 64'd0);
    tick();
    chk("gap_start_k2", 64'(bus_a.start), 64'd1);
    chk("gap_radicand", 64'(bus_a.radicand), 64'd21);
    tick();
    chk("gap_start_drop", 64'(bus_a.start), 64'd0);

    // Back-to-back windows 1..4 (30>>2=7) and 5..8 (174>>2=43)
    for (int i = 1; i <= 8; i++) begin
      put_a(1'b1, 32'(i));
      tick();
      if (i == 6) begin
        chk("b2b_start1", 64'(bus_a.start), 64'd1);
        chk("b2b_radicand1", 64'(bus_a.radicand), 64'd7);
      end else begin
        chk("b2b_start_low", 64'(bus_a.start), 64'd0);
      end
    end
    put_a(1'b0, 32'd0);
    tick();
    chk("b2b_start_low9", 64'(bus_a.start), 64'd0);
    tick();
    chk("b2b_start2", 64'(bus_a.start), 64'd1);
    chk("b2b_radicand2", 64'(bus_a.radicand), 64'd43);

    // Clear flushes 100,100 and drops the sample presented with it
    put_a(1'b1, 32'd100);
    tick();
    tick();
    put_a(1'b1, 32'd50);
    bus_a.clear = 1'b1;
    tick();
    chk("clr_radicand_kept", 64'(bus_a.radicand), 64'd43);
    bus_a.clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put_a(i < 4, 32'd2);
      tick();
      chk("clr_no_start", 64'(bus_a.start), 64'd0);
    end
    put_a(1'b0, 32'd0);
    tick();
    chk("clr_start", 64'(bus_a.start), 64'd1);
    chk("clr_radicand", 64'(bus_a.radicand), 64'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_single_start", 64'(bus_a.start), 64'd0);
    end

    // Defaults: 16 x -2^31 -> 2^66 >> 4 = 2^62, then 16 zeros -> 0
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 16; i++) begin
        put_b(1'b1, (w == 0) ? 32'h8000_0000 : 32'd0);
        tick();
      end
      put_b(1'b0, 32'd0);
      tick();
      tick();
      chk("def_start", 64'(bus_b.start), 64'd1);
      chk("def_radicand", 64'(bus_b.radicand), (w == 0) ? 64'h4000_0000_0000_0000 : 64'd0);
      chk("def_overflow", 64'(bus_b.overflow), 64'd0);
    end

    // Narrow output: 4 x 0x8000 saturates, then a window of 1s clears overflow
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        put_c(1'b1, (w == 0) ? 16'h8000 : 16'd1);
        tick();
      end
      put_c(1'b0, 16'd0);
      tick();
      tick();
      chk("sat_start", 64'(bus_c.start), 64'd1);
      chk("sat_radicand", 64'(bus_c.radicand), (w == 0) ? 64'hFFFF : 64'd1);
      chk("sat_overflow", 64'(bus_c.overflow), (w == 0) ? 64'd1 : 64'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
